// File: rtl/dma_irq_coalescer.sv
// dma_irq_coalescer: counts DMA read/write completions per channel, coalesces
// them into pending interrupt bits by count threshold or idle timeout, and
// exposes pending/enable/coalescing/counter registers on a 64-bit register bus.

package dma_irq_coalescer_pkg;
  typedef struct packed {
    logic [5:0]  addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module dma_irq_coalescer #(
  parameter type         reg_req_t = dma_irq_coalescer_pkg::reg_req_t,
  parameter type         reg_rsp_t = dma_irq_coalescer_pkg::reg_rsp_t,
  parameter int unsigned CntWidth  = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  input  logic       rd_done_i,
  input  logic       wr_done_i,
  output logic [1:0] irq_o
);

  localparam logic [5:0] AddrIpsr  = 6'h00;
  localparam logic [5:0] AddrIer   = 6'h08;
  localparam logic [5:0] AddrCoal  = 6'h10;
  localparam logic [5:0] AddrRdCnt = 6'h18;
  localparam logic [5:0] AddrWrCnt = 6'h20;

  logic [1:0]          ipsr_q, ipsr_d;
  logic [1:0]          ier_q, ier_d;
  logic [7:0]          thresh_q, thresh_d;
  logic [15:0]         timeout_q, timeout_d;
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]          done;
  logic [1:0]          fire_vec;
  logic [1:0]          w1c_mask;
  logic [7:0]          eff_thresh;
  logic                wr_en;
  logic                unused_bits;

  assign done       = {wr_done_i, rd_done_i};
  assign wr_en      = reg_req_i.valid & reg_req_i.write;
  // A threshold of zero behaves like one: every completion interrupts.
  assign eff_thresh = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  assign irq_o      = ipsr_q & ier_q;
  assign unused_bits = ^{reg_req_i.wdata[63:32], reg_req_i.wdata[15:8],
                         reg_req_i.wstrb[7:4], reg_req_i.wstrb[1]};

  // Combinational read decode; the response is all-zero when no request is valid.
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    if (reg_req_i.valid) begin
      case (reg_req_i.addr)
        AddrIpsr:  reg_rsp_o.rdata = {62'd0, ipsr_q};
        AddrIer:   reg_rsp_o.rdata = {62'd0, ier_q};
        AddrCoal:  reg_rsp_o.rdata = {32'd0, timeout_q, 8'd0, thresh_q};
        AddrRdCnt: reg_rsp_o.rdata = 64'(rd_cnt_q);
        AddrWrCnt: reg_rsp_o.rdata = 64'(wr_cnt_q);
        default:   reg_rsp_o.error = 1'b1;
      endcase
    end
  end

  // Register writes with byte strobes, W1C pending bits (set beats clear), lifetime counters.
  always_comb begin
    ier_d     = ier_q;
    thresh_d  = thresh_q;
    timeout_d = timeout_q;
    w1c_mask  = 2'b00;
    if (wr_en) begin
      case (reg_req_i.addr)
        AddrIpsr: if (reg_req_i.wstrb[0]) w1c_mask = reg_req_i.wdata[1:0];
        AddrIer:  if (reg_req_i.wstrb[0]) ier_d = reg_req_i.wdata[1:0];
        AddrCoal: begin
          if (reg_req_i.wstrb[0]) thresh_d = reg_req_i.wdata[7:0];
          if (reg_req_i.wstrb[2]) timeout_d[7:0] = reg_req_i.wdata[23:16];
          if (reg_req_i.wstrb[3]) timeout_d[15:8] = reg_req_i.wdata[31:24];
        end
        default: ;
      endcase
    end
    ipsr_d   = (ipsr_q & ~w1c_mask) | fire_vec;
    rd_cnt_d = rd_cnt_q + CntWidth'(rd_done_i);
    wr_cnt_d = wr_cnt_q + CntWidth'(wr_done_i);
  end

  // Register state update.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ipsr_q    <= '0;
      ier_q     <= '0;
      thresh_q  <= '0;
      timeout_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      ipsr_q    <= ipsr_d;
      ier_q     <= ier_d;
      thresh_q  <= thresh_d;
      timeout_q <= timeout_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Channel 0 is read completions, channel 1 is write completions.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [7:0]  pend_q, pend_d, pend_inc;
    logic [15:0] tmr_q, tmr_d;
    logic        fire_q, fire_d, timeout_hit;

    // Count the pulse, decide on a fire, and advance the idle timer.
    always_comb begin
      pend_inc    = (done[gi] && (pend_q != 8'hFF)) ? pend_q + 8'd1 : pend_q;
      timeout_hit = (timeout_q != 16'd0) && (pend_q != 8'd0) && !done[gi] &&
                    (tmr_q == timeout_q - 16'd1);
      fire_d      = (pend_inc >= eff_thresh) || timeout_hit;
      pend_d      = pend_inc;
      tmr_d       = tmr_q + 16'd1;
      if (fire_d) begin
        pend_d = 8'd0;
        tmr_d  = 16'd0;
      end else if (done[gi] || (pend_q == 8'd0)) begin
        tmr_d  = 16'd0;
      end
    end

    // Fire decision is registered, so the pending bit lands one edge later.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pend_q <= '0;
        tmr_q  <= '0;
        fire_q <= 1'b0;
      end else begin
        pend_q <= pend_d;
        tmr_q  <= tmr_d;
        fire_q <= fire_d;
      end
    end

    assign fire_vec[gi] = fire_q;
  end

endmodule

// File: doc/dma_irq_coalescer.md
# dma_irq_coalescer

Completion-to-interrupt stage sitting directly downstream of the DMA core wrapper. It consumes per-transfer read-done and write-done pulses from the DMA backend and coalesces them per channel by count threshold and idle timeout. It maintains W1C pending bits (`ipsr.rip`, `ipsr.wip`) plus enable, coalescing and counter registers, and drives the wired interrupt lines to the platform interrupt controller. Configuration and status are reached over a 64-bit register-bus slave, placed behind the same AXI-to-reg translation as the DMA frontend.

## Interface
- `reg_req_t`, default none: register-bus request type with fields `addr[5:0]`, `write`, `wdata[63:0]`, `wstrb[7:0]`, `valid`.
- `reg_rsp_t`, default none: register-bus response type with fields `rdata[63:0]`, `error`, `ready`.
- `CntWidth`, default 32: width of the lifetime completion counters.
- `clk_i`  in  1  clock, the only clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `reg_req_i`  in  reg_req_t  configuration/status request.
- `reg_rsp_o`  out  reg_rsp_t  configuration/status response.
- `rd_done_i`  in  1  one-cycle pulse per completed read transfer.
- `wr_done_i`  in  1  one-cycle pulse per completed write transfer.
- `irq_o`  out  2  `irq_o[0]` = `rip & ier.re`; `irq_o[1]` = `wip & ier.we`.

## Operation
- Register map (byte address, 8-byte aligned). Any other address returns `error=1`, `rdata=0`, and writes to it have no effect.
  - 0x00 IPSR: bit0 `rip`, bit1 `wip`. Writing 1 to a bit clears it (W1C); writing 0 leaves it unchanged.
  - 0x08 IER: bit0 `re`, bit1 `we`. Read/write.
  - 0x10 COAL: [7:0] `thresh`, [31:16] `timeout`. Read/write, and applies to both channels.
  - 0x18 RDCNT: read-only; total `rd_done_i` pulses, wraps modulo 2^CntWidth.
  - 0x20 WRCNT: read-only; same as RDCNT for `wr_done_i`.
  - Writes to read-only registers are ignored with `error=0`.
  - Byte strobes are honoured per byte.
- Two identical independent channels (rd, wr). Each has:
  - `pend` counter, 8 bits, saturating at 255.
  - `tmr` counter, 16 bits.
- Effective threshold is `max(thresh,1)`.
- Per-channel fire condition, evaluated each cycle after the done pulse is counted: `pend_next >= eff_thresh`, OR (`timeout != 0` AND `pend != 0` AND `tmr == timeout-1` AND no done pulse this cycle).
- On fire:
  - the channel's IPSR bit is set on the next edge;
  - `pend` resets to 0;
  - `tmr` resets to 0.
- `tmr` behaviour:
  - clears on every done pulse;
  - increments while `pend != 0`;
  - holds at 0 while `pend == 0`.
- Simultaneous W1C clear and fire on the same bit in the same cycle: set wins and the bit stays 1.
- IER gates only `irq_o`. Pending bits set regardless of IER.
- A COAL write takes effect on the following cycle. If the new threshold is `<= pend`, the channel fires on that next cycle.

## Timing
- Reset values: all registers 0, `pend=0`, `tmr=0`, `irq_o=2'b00`, `reg_rsp_o` all fields 0.
- Register bus:
  - `ready = valid` combinationally;
  - `rdata` and `error` are combinational from current state;
  - writes commit on the clock edge where `valid & write`.
- Done pulse at edge N with threshold met: IPSR bit is 1 after edge N+1, and `irq_o` is high in that same cycle (registered bit, combinational AND with IER).
- Timeout `T`: with the last pulse counted at edge N, the fire is evaluated at edge N+T and the bit is visible after edge N+T+1.
- Counters RDCNT/WRCNT update at the edge following the pulse.
- Reset asserted mid-coalescing drops all pending counts. No interrupt is produced for pre-reset completions.
- `rd_done_i` and `wr_done_i` may pulse in the same cycle and on back-to-back cycles; every pulse is counted.

## Test plan
- Reset, then read all five registers: every field reads 0, `irq_o=00`, `error=0`; a read of 0x28 gives `error=1`.
- IER=3, COAL `thresh=1`, `timeout=0`, one `rd_done_i` pulse: `rip=1` and `irq_o=01` two edges after the pulse. Write IPSR=1: `rip=0`, `irq_o=00`.
- COAL `thresh=4`, `timeout=0`, three `wr_done_i` pulses: `wip` stays 0 and WRCNT=3. A fourth pulse sets `wip` and `irq_o[1]=1`; WRCNT=4.
- COAL `thresh=8`, `timeout=10`, two rd pulses then idle: `rip` rises exactly 11 edges after the last pulse. A pulse arriving at idle cycle 5 restarts the 10-cycle window.
- `rip=1` pending; in the same cycle a W1C of bit0 coincides with a fire on rd (thresh=1): `rip` remains 1.
- Reset asserted with `pend=3`, then deasserted with thresh=4, then one pulse: no fire; `pend=1`.
